whack_game_ctrl: RTL

Game sequencer for the whack-a-box datapath. It owns the round state machine: lobby, target selection, hit window, scoring and game-over. It drives the VGA level/MIF select and the audio triggers, and consumes the box address decoded from the Arduino GPIO sensor path. It replaces the ad-hoc switch-driven level selection: the VGA fill block and the audio units take their control from this block.

---
 rtl/whack_game_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/whack_game_ctrl.sv
// Round sequencer for the whack-a-box game: lobby, target pick, hit window,
// scoring and game-over. Drives the fill MIF select and the audio enables.
//
// state | meaning
// LOBBY | idle, lobby music on, waits for start
// ARM   | board blank, picking the next target from the LFSR
// SHOW  | target lit, hit window running
// HIT   | correct box hit, hit sound held for SOUND_TICKS
// MISS  | window expired, blank-board gap for GAP_TICKS
// OVER  | game timer ran out, final score held until start
module whack_game_ctrl #(
  parameter int          TICK_DIV    = 5_000_000,
  parameter int          GAME_TICKS  = 600,
  parameter int          NUM_BOXES   = 6,
  parameter int          WIN0        = 20,
  parameter int          WIN1        = 12,
  parameter int          WIN2        = 7,
  parameter int          SOUND_TICKS = 3,
  parameter int          GAP_TICKS   = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  box_address,
  output logic [3:0]  level_select,
  output logic        play_sound,
  output logic        lobby_sound,
  output logic [10:0] score,
  output logic [1:0]  difficulty,
  output logic [9:0]  time_left,
  output logic        game_active
);

  typedef enum logic [2:0] {LOBBY, ARM, SHOW, HIT, MISS, OVER} state_t;

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [2:0]      NB       = 3'(NUM_BOXES);
  localparam logic [9:0]      GT       = 10'(GAME_TICKS);
  localparam logic [7:0]      W0       = 8'(WIN0);
  localparam logic [7:0]      W1       = 8'(WIN1);
  localparam logic [7:0]      W2       = 8'(WIN2);
  localparam logic [7:0]      SND      = 8'(SOUND_TICKS);
  localparam logic [7:0]      GAP      = 8'(GAP_TICKS);

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q;
  logic [7:0]    lfsr_q;
  logic [2:0]    prev_q, prev_d, target_q, target_d, cand;
  logic [7:0]    win_q, win_d, cnt_q, cnt_d, win_sel;
  logic [10:0]   score_d;
  logic [9:0]    time_d;
  logic [3:0]    lvl_d;
  logic [2:0]    s1, s2, s3;
  logic          tick, hit_evt, pre_clr, active_q, active_d;

  assign tick     = (pre_q == PRE_LAST);
  assign hit_evt  = (s2 != s3) && (s2 != 3'd0);
  assign cand     = lfsr_q[2:0];
  assign active_q = (state_q == ARM) || (state_q == SHOW) || (state_q == HIT) || (state_q == MISS);
  assign active_d = (state_d == ARM) || (state_d == SHOW) || (state_d == HIT) || (state_d == MISS);

  // Window length for the target about to be shown, from the current difficulty.
  always_comb begin
    win_sel = W0;
    case (difficulty)
      2'd1:    win_sel = W1;
      2'd2:    win_sel = W2;
      default: win_sel = W0;
    endcase
  end

  // Next state, round counters and score; the game timer overrides everything.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    prev_d   = prev_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    score_d  = score;
    time_d   = time_left;
    pre_clr  = 1'b0;
    case (state_q)
      LOBBY, OVER: begin
        if (start) begin
          state_d = ARM;
          score_d = '0;
          time_d  = GT;
          pre_clr = 1'b1;
        end
      end
      ARM: begin
        if ((cand != 3'd0) && (cand <= NB) && (cand != prev_q)) begin
          target_d = cand;
          prev_d   = cand;
          win_d    = win_sel;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (hit_evt && (s2 == target_q)) begin
          score_d = (score == 11'd2047) ? score : score + 11'd1;
          cnt_d   = SND;
          state_d = HIT;
        end else begin
          if (hit_evt)
            score_d = (score == 11'd0) ? score : score - 11'd1;
          if (tick) begin
            win_d = win_q - 8'd1;
            if (win_q == 8'd1) begin
              cnt_d   = GAP;
              state_d = MISS;
            end
          end
        end
      end
      HIT, MISS: begin
        if (tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1)
            state_d = ARM;
        end
      end
      default: state_d = LOBBY;
    endcase
    if (active_q && tick) begin
      time_d = time_left - 10'd1;
      if (time_left == 10'd1)
        state_d = OVER;
    end
    case (state_d)
      LOBBY:   lvl_d = 4'd0;
      SHOW:    lvl_d = {1'b0, target_d};
      OVER:    lvl_d = 4'd15;
      default: lvl_d = 4'd7;
    endcase
  end

  // Prescaler, LFSR and the sensor synchronizer run every cycle in every state.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pre_q  <= '0;
      lfsr_q <= LFSR_SEED;
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
    end else begin
      pre_q  <= (pre_clr || tick) ? '0 : pre_q + PW'(1);
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      s1     <= box_address;
      s2     <= s1;
      s3     <= s2;
    end
  end

  // State, round registers and registered outputs, all updated together.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= LOBBY;
      target_q     <= '0;
      prev_q       <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      score        <= '0;
      difficulty   <= 2'd0;
      time_left    <= GT;
      level_select <= 4'd0;
      play_sound   <= 1'b0;
      lobby_sound  <= 1'b1;
      game_active  <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      prev_q       <= prev_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      score        <= score_d;
      difficulty   <= (score < 11'd10) ? 2'd0 : (score < 11'd25) ? 2'd1 : 2'd2;
      time_left    <= time_d;
      level_select <= lvl_d;
      play_sound   <= (state_d == HIT);
      lobby_sound  <= (state_d == LOBBY);
      game_active  <= active_d;
    end
  end

endmodule
